// File: rtl/instruction_sequencer.sv
// instruction_sequencer: host-loaded instruction memory and PC sequencer that
// presents one instruction per issue slot to the decoder.
module instruction_sequencer #(
  parameter int IMEM_DEPTH = 256,
  parameter int PC_W       = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            prog_we,
  input  logic [PC_W-1:0] prog_addr,
  input  logic [15:0]     prog_data,
  input  logic            start,
  input  logic            stall,
  output logic [15:0]     instruction,
  output logic            instr_valid,
  output logic [PC_W-1:0] pc,
  output logic            running,
  output logic            halted,
  output logic            error
);
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, WAIT, HALT} state_t;
  state_t state, nxt;
  logic [15:0] mem [IMEM_DEPTH];
  logic [15:0] rdata;
  logic [2:0] op;
  logic multi, at_end, pc_clr, pc_inc, set_err;
  assign rdata  = mem[pc];
  assign op     = instruction[15:13];
  assign multi  = op >= 3'd2 && op <= 3'd5;
  assign at_end = pc == PC_W'(IMEM_DEPTH - 1);
  always_ff @(posedge clk)
    if (prog_we && (state == IDLE || state == HALT)) mem[prog_addr] <= prog_data;
  // A fetched HALT word goes straight to HALT so the decoder never sees it.
  always_comb begin
    nxt     = state;
    pc_clr  = 1'b0;
    pc_inc  = 1'b0;
    set_err = 1'b0;
    case (state)
      IDLE, HALT: if (start) begin
        nxt    = FETCH;
        pc_clr = 1'b1;
      end
      FETCH: nxt = rdata[15:13] == 3'b111 ? HALT : EXEC;
      EXEC: if (op == 3'b111) nxt = HALT;
        else if (multi) nxt = WAIT;
        else begin
          nxt     = at_end ? HALT : FETCH;
          pc_inc  = !at_end;
          set_err = at_end;
        end
      WAIT: if (!stall) begin
        nxt     = at_end ? HALT : FETCH;
        pc_inc  = !at_end;
        set_err = at_end;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state       <= IDLE;
      pc          <= '0;
      instruction <= '0;
      error       <= 1'b0;
    end else begin
      state       <= nxt;
      pc          <= pc_clr ? '0 : pc_inc ? pc + 1'b1 : pc;
      instruction <= (state == FETCH && nxt == EXEC) ? rdata : '0;
      error       <= pc_clr ? 1'b0 : (error | set_err);
    end
  assign instr_valid = state == EXEC;
  assign running     = state == FETCH || state == EXEC || state == WAIT;
  assign halted      = state == HALT;
endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer: vector table, hand-written corner sequences and
// random programs checked against a per-instruction timing model.
module tb_instruction_sequencer;
  logic clk = 0, reset = 0, prog_we = 0, start = 0, stall = 0;
  logic [7:0] prog_addr = 0;
  logic [15:0] prog_data = 0;
  logic [15:0] instruction;
  logic instr_valid, running, halted, error;
  logic [7:0] pc;
  int checks = 0, failures = 0, viol = 0;
  logic [15:0] sh [256];
  int stall_len [256];
  int act_cyc[$], exp_cyc[$];
  logic [15:0] act_w[$], exp_w[$];
  int act_halt, exp_halt, exp_pc;
  logic [7:0] act_pc;
  logic act_err, exp_err;
  bit prev_v = 0;

  typedef struct {
    logic [15:0] w0, w1, w2, w3;
    int s, slots, last_cyc;
    logic [15:0] last_w;
    int pc, err, halt;
  } vec_t;
  vec_t tbl [6];

  instruction_sequencer #(.IMEM_DEPTH(256), .PC_W(8)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .stall(stall),
    .instruction(instruction), .instr_valid(instr_valid), .pc(pc),
    .running(running), .halted(halted), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset) begin
      if (!instr_valid && instruction != 16'h0) viol++;
      if (instr_valid && prev_v) viol++;
      if (halted && running) viol++;
    end
    prev_v = instr_valid;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_multi(input logic [15:0] w);
    return w[15:13] >= 3'd2 && w[15:13] <= 3'd5;
  endfunction

  function automatic logic [15:0] rand_nonhalt();
    logic [15:0] w;
    w = 16'($urandom);
    w[15:13] = 3'($urandom_range(0, 6));
    return w;
  endfunction

  task automatic prog(input logic [7:0] a, input logic [15:0] d);
    prog_we = 1; prog_addr = a; prog_data = d; sh[a] = d;
    tick();
    prog_we = 0;
  endtask

  // Start a run; after each multi-cycle issue hold stall for stall_len[slot]
  // WAIT cycles, otherwise drive stall randomly (it must be ignored there).
  task automatic run(input bit wr, input logic [7:0] wa, input logic [15:0] wd, input int budget);
    int cyc, rem, n;
    bit win;
    act_cyc.delete(); act_w.delete();
    rem = 0; win = 0; n = 0;
    start = 1; stall = 1'($urandom_range(0, 1));
    if (wr) begin prog_we = 1; prog_addr = wa; prog_data = wd; sh[wa] = wd; end
    tick();
    start = 0; prog_we = 0; cyc = 1;
    while (!halted && cyc < budget) begin
      if (win) begin
        stall = rem > 0;
        if (rem == 0) win = 0; else rem--;
      end else stall = 1'($urandom_range(0, 1));
      if (instr_valid) begin
        act_cyc.push_back(cyc); act_w.push_back(instruction);
        if (is_multi(instruction)) begin win = 1; rem = stall_len[n]; end
        n++;
      end
      tick();
      cyc++;
    end
    act_halt = halted ? cyc : -1; act_pc = pc; act_err = error; stall = 0;
  endtask

  // Cycle 0 holds start; each instruction costs 2 cycles, multi-cycle ones
  // 3 + stall cycles; a fetched HALT halts one cycle after its fetch.
  task automatic model();
    int f, p, nf;
    logic [15:0] w;
    exp_cyc.delete(); exp_w.delete();
    f = 1; p = 0; exp_halt = -2; exp_err = 0;
    for (int k = 0; k < 300; k++) begin
      w = sh[p];
      if (w[15:13] == 3'b111) begin exp_halt = f + 1; break; end
      exp_cyc.push_back(f + 1); exp_w.push_back(w);
      nf = is_multi(w) ? f + 3 + stall_len[k] : f + 2;
      if (p == 255) begin exp_halt = nf; exp_err = 1; break; end
      p++; f = nf;
    end
    exp_pc = p;
  endtask

  task automatic compare(input string nm);
    int m;
    model();
    chk($sformatf("%s slots", nm), act_cyc.size(), exp_cyc.size());
    m = act_cyc.size() < exp_cyc.size() ? act_cyc.size() : exp_cyc.size();
    for (int i = 0; i < m; i++) begin
      chk($sformatf("%s slot%0d cycle", nm, i), act_cyc[i], exp_cyc[i]);
      chk($sformatf("%s slot%0d word", nm, i), act_w[i], exp_w[i]);
    end
    chk($sformatf("%s halt cycle", nm), act_halt, exp_halt);
    chk($sformatf("%s pc", nm), act_pc, exp_pc);
    chk($sformatf("%s error", nm), act_err, exp_err);
  endtask

  task automatic rand_stalls(input int mx);
    for (int k = 0; k < 256; k++) stall_len[k] = $urandom_range(0, mx);
  endtask

  initial begin
    int l, lim;
    tbl[0] = '{16'h2005, 16'hE000, 16'h0000, 16'h0000, 0, 1, 2, 16'h2005, 1, 0, 4};
    tbl[1] = '{16'h4000, 16'hE000, 16'h0000, 16'h0000, 5, 1, 2, 16'h4000, 1, 0, 10};
    tbl[2] = '{16'h0000, 16'h2000, 16'h8000, 16'hE000, 0, 3, 6, 16'h8000, 3, 0, 9};
    tbl[3] = '{16'hE000, 16'h0000, 16'h0000, 16'h0000, 0, 0, -1, 16'h0000, 0, 0, 2};
    tbl[4] = '{16'hA000, 16'h6000, 16'hC000, 16'hE000, 2, 3, 12, 16'hC000, 3, 0, 14};
    tbl[5] = '{16'h0000, 16'h0000, 16'hE000, 16'h0000, 0, 2, 4, 16'h0000, 2, 0, 6};
    tick(); tick();
    chk("reset instruction", instruction, 0);
    chk("reset instr_valid", instr_valid, 0);
    chk("reset pc", pc, 0);
    chk("reset running", running, 0);
    chk("reset halted", halted, 0);
    chk("reset error", error, 0);
    reset = 1;
    tick();

    for (int v = 0; v < 6; v++) begin
      prog(0, tbl[v].w0); prog(1, tbl[v].w1); prog(2, tbl[v].w2); prog(3, tbl[v].w3);
      for (int k = 0; k < 256; k++) stall_len[k] = tbl[v].s;
      run(0, 0, 0, 100);
      chk($sformatf("vec%0d slots", v), act_cyc.size(), tbl[v].slots);
      chk($sformatf("vec%0d last slot cycle", v), act_cyc.size() ? act_cyc[$] : -1, tbl[v].last_cyc);
      chk($sformatf("vec%0d last word", v), act_w.size() ? act_w[$] : 16'h0, tbl[v].last_w);
      chk($sformatf("vec%0d pc", v), act_pc, tbl[v].pc);
      chk($sformatf("vec%0d error", v), act_err, tbl[v].err);
      chk($sformatf("vec%0d halt cycle", v), act_halt, tbl[v].halt);
    end

    // Async reset while a STORE is stalled in WAIT.
    prog(0, 16'h0000); prog(1, 16'hA000); prog(2, 16'hE000);
    stall = 1; start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 7; i++) tick();
    chk("wait running", running, 1);
    chk("wait pc", pc, 1);
    chk("wait instr_valid", instr_valid, 0);
    #2 reset = 0;
    #1;
    chk("async instruction", instruction, 0);
    chk("async instr_valid", instr_valid, 0);
    chk("async pc", pc, 0);
    chk("async running", running, 0);
    chk("async halted", halted, 0);
    chk("async error", error, 0);
    tick();
    reset = 1; stall = 0;
    tick();
    rand_stalls(3);
    run(1, 0, 16'h2005, 100);
    compare("restart");

    // Write and start during WAIT are ignored; the same write in HALT lands.
    prog(0, 16'h4000); prog(1, 16'h0000); prog(2, 16'hE000);
    stall = 1; start = 1;
    tick();
    start = 0;
    tick();
    chk("seq2 issue valid", instr_valid, 1);
    chk("seq2 issue word", instruction, 16'h4000);
    tick();
    prog_we = 1; prog_addr = 1; prog_data = 16'h8000; start = 1;
    tick();
    prog_we = 0; start = 0;
    chk("seq2 start ignored running", running, 1);
    chk("seq2 start ignored pc", pc, 0);
    chk("seq2 start ignored valid", instr_valid, 0);
    stall = 0;
    tick();
    chk("seq2 fetch pc", pc, 1);
    tick();
    chk("seq2 second valid", instr_valid, 1);
    chk("seq2 write ignored", instruction, 16'h0000);
    lim = 0;
    while (!halted && lim < 10) begin tick(); lim++; end
    chk("seq2 halted", halted, 1);
    chk("seq2 halt pc", pc, 2);
    prog(1, 16'h8000);
    rand_stalls(2);
    run(0, 0, 0, 100);
    chk("seq2 rewritten word", act_w.size() > 1 ? act_w[1] : 16'h0, 16'h8000);
    compare("seq2 rerun");

    for (int r = 0; r < 6; r++) begin
      l = $urandom_range(1, 10);
      for (int i = 0; i < l; i++) prog(8'(i), rand_nonhalt());
      prog(8'(l), 16'hE000 | 16'($urandom_range(0, 16'h1FFF)));
      rand_stalls(4);
      run(0, 0, 0, 400);
      compare($sformatf("rand%0d", r));
    end

    // Whole memory without HALT: runs off the end, no wrap.
    for (int i = 0; i < 256; i++) prog(8'(i), rand_nonhalt());
    rand_stalls(2);
    run(0, 0, 0, 3000);
    chk("end slots", act_cyc.size(), 256);
    chk("end pc", act_pc, 255);
    chk("end error", act_err, 1);
    compare("end");

    chk("invariants", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instruction_sequencer.md
# instruction_sequencer

Program sequencer that sits directly upstream of the instruction decoder. It holds a small instruction memory that the host loads, and runs a program counter through it. It presents one 16-bit instruction per issue slot on `instruction`, which feeds the decoder's instruction input. Multi-cycle opcodes hold the sequencer until the datapath releases `stall`; execution stops at a HALT opcode or at the end of memory.

## Interface
- IMEM_DEPTH, 256, number of 16-bit instruction words
- PC_W, 8, program counter width; IMEM_DEPTH == 2**PC_W
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; 0 = reset asserted
- prog_we  in  1  host write strobe into instruction memory
- prog_addr  in  PC_W  host write address
- prog_data  in  16  host write data
- start  in  1  begin execution at address 0
- stall  in  1  datapath busy; holds sequencer in WAIT
- instruction  out  16  instruction to decoder; 16'h0000 (NOP) outside issue slot
- instr_valid  out  1  high during the issue slot
- pc  out  PC_W  address of the current/last issued instruction
- running  out  1  high in FETCH, EXEC, WAIT
- halted  out  1  high in HALT
- error  out  1  program ran off end of memory without HALT

## Operation
- Opcode is `instruction[15:13]`:
  - 000 NOP, 001 LOAD_ADDR, 110 reserved: single-cycle
  - 010 LOAD_WEIGHT, 011 LOAD_INPUTS, 100 VALID, 101 STORE: multi-cycle
  - 111 HALT
- Memory: synchronous write, synchronous 1-cycle read; contents are not reset.
- prog_we is honoured only in IDLE or HALT; it is ignored in all other states.
- States: IDLE, FETCH, EXEC, WAIT, HALT.
- IDLE: start=1 → FETCH, pc←0, error←0.
- FETCH: instruction←mem[pc], instr_valid←1 → EXEC.
- EXEC (issue slot, exactly one cycle):
  - HALT opcode → HALT; pc unchanged.
  - Multi-cycle opcode → WAIT.
  - Single-cycle opcode → FETCH, pc←pc+1.
  - If pc == IMEM_DEPTH-1 and the opcode is not HALT: the next state is HALT with error←1 instead of FETCH (after WAIT if multi-cycle). pc does not wrap.
- Leaving EXEC: instruction←0, instr_valid←0.
- WAIT: at each edge, stall=0 → pc←pc+1 and FETCH (or HALT+error at end of memory); stall=1 → remain. There is a minimum of one WAIT cycle.
- HALT: instruction=0, halted=1. start=1 → FETCH, pc←0, error←0.
- start is ignored in FETCH, EXEC and WAIT.
- The HALT instruction word itself is never presented on `instruction`. The decoder sees a NOP and only `halted` changes.

## Timing
- Reset (async, reset=0): state IDLE, pc=0, instruction=0, instr_valid=0, running=0, halted=0, error=0, all immediately. Reset mid-program aborts without completing WAIT.
- Start latency: start sampled at edge E0 → FETCH; E1 → EXEC. `instruction`=mem[0] and instr_valid=1 during the cycle after E1.
- Single-cycle opcodes take 2 cycles per instruction (FETCH+EXEC).
- Multi-cycle opcodes take 2 cycles plus the WAIT cycles. The datapath must raise stall no later than the first WAIT cycle (i.e. the cycle after the issue slot).
- stall is ignored outside WAIT.
- `instruction` is registered. The decoder's outputs are therefore one-cycle pulses aligned to instr_valid. LOAD_ADDR's base address is latched downstream during that slot.
- `pc` changes only on FETCH entry from EXEC/WAIT, or on reset/start.
- prog_we with start in the same IDLE cycle: the write completes and execution begins. The write is visible if it targets address 0 because FETCH reads at the next edge.

## Test plan
- Program mem[0]=16'h2005 (LOAD_ADDR 5), mem[1]=16'hE000 (HALT); pulse start → instruction=16'h2005 with instr_valid for exactly 1 cycle, 2 edges after start. halted=1 two cycles later, pc=1, error=0, instruction stays 0.
- mem[0]=16'h4000 (LOAD_WEIGHT), mem[1]=HALT; hold stall=1 for 5 cycles after the issue slot → sequencer stays in WAIT 5 cycles, pc=0. After stall drops, the next issue of HALT leads to halted=1 with pc=1.
- Fill all 256 words with NOP, then start → 256 issue slots, pc ends 255, halted=1, error=1, no wrap to 0.
- Pulse reset=0 during WAIT of a STORE (16'hA000) → all outputs 0 in the same cycle. After release, start re-runs from pc=0.
- In WAIT, assert prog_we to mem[1] with 16'h8000 and pulse start → memory unchanged, start ignored. In HALT, the same write succeeds and restart issues 16'h8000 second.
- Back-to-back NOP, LOAD_ADDR, VALID (stall low) → issue slots at cycles 2, 4, and 6. instr_valid is never high two consecutive cycles.
